// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES round scheduler.
// Define AES_KEY256_EN to select AES-256 (14 rounds); otherwise AES-128 (10 rounds).
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_256 = 14;

`ifdef AES_KEY256_EN
  localparam int unsigned NR = NR_256;
`else
  localparam int unsigned NR = NR_128;
`endif

  // Round count at the round-counter width, for direct comparison.
  localparam logic [3:0] NrLast = 4'(NR);

  typedef enum logic [2:0] {
    StIdle,
    StInitKey,
    StCol,
    StKey,
    StDone
  } aes_state_e;

endpackage

// File: rtl/aes_round_sched.sv
// Control FSM sequencing one AES block through a shared column unit and key adder.
// Round count comes from aes_pkg::NR, selected by the AES_KEY256_EN macro.
module aes_round_sched
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  input  logic       key_valid,
  output logic [3:0] round_num,
  output logic       col_en,
  output logic [1:0] col_sel,
  output logic       mix_en,
  output logic       add_key_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  aes_state_e state_q;
  logic [3:0] round_q;
  logic [1:0] col_q;
  logic       last_round;

  assign last_round = (round_q == NrLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      col_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            round_q <= '0;
            state_q <= StInitKey;
          end
        end
        StInitKey: begin
          if (key_valid) begin
            round_q <= 4'd1;
            col_q   <= '0;
            state_q <= StCol;
          end
        end
        StCol: begin
          // Column counter wraps to 0 on the last column, ready for the next round.
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= StKey;
          end
        end
        StKey: begin
          if (key_valid) begin
            if (last_round) begin
              state_q <= StDone;
            end else begin
              round_q <= round_q + 4'd1;
              state_q <= StCol;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes that depend on a handshake input are suppressed while reset is applied,
  // so a block presented alongside reset is never reported as captured.
  always_comb begin
    in_ready   = 1'b0;
    load_en    = 1'b0;
    col_en     = 1'b0;
    mix_en     = 1'b0;
    add_key_en = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        load_en  = in_valid & ~rst;
      end
      StInitKey: add_key_en = key_valid & ~rst;
      StCol: begin
        col_en = 1'b1;
        mix_en = ~last_round;
      end
      StKey:  add_key_en = key_valid & ~rst;
      StDone: out_valid  = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign round_num = round_q;
  assign col_sel   = col_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({col_en, add_key_en, load_en}));

  a_round_bound: assert property (@(posedge clk) disable iff (rst)
    round_q <= NrLast);

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomised and directed bench for aes_round_sched against an operation-list model.
// Honours AES_KEY256_EN to select the expected round count.
module tb_aes_round_sched;

`ifdef AES_KEY256_EN
  localparam int Nr = 14;
`else
  localparam int Nr = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       load_en;
  logic       key_valid = 1'b0;
  logic [3:0] round_num;
  logic       col_en;
  logic [1:0] col_sel;
  logic       mix_en;
  logic       add_key_en;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  aes_round_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .key_valid  (key_valid),
    .round_num  (round_num),
    .col_en     (col_en),
    .col_sel    (col_sel),
    .mix_en     (mix_en),
    .add_key_en (add_key_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // The model keeps the remaining work of an in-flight block as a list of operations.
  typedef enum {OpInitKey, OpCol, OpKey, OpDone} op_kind_e;
  typedef struct {
    op_kind_e kind;
    int       rnd;
    int       col;
  } op_t;

  op_t  ops[$];
  int   idle_round = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic obs_ov = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {in_ready, load_en, busy, col_en, col_sel, mix_en, add_key_en, out_valid, round_num}
  function automatic logic [12:0] model_out(input logic iv, input logic kv);
    logic       rdy, ld, bsy, ce, me, ak, ov;
    logic [1:0] cs;
    logic [3:0] rn;
    rdy = 0; ld = 0; bsy = 0; ce = 0; me = 0; ak = 0; ov = 0; cs = 0; rn = 0;
    if (ops.size() == 0) begin
      rdy = 1;
      ld  = iv;
      rn  = 4'(idle_round);
    end else begin
      bsy = 1;
      rn  = 4'(ops[0].rnd);
      case (ops[0].kind)
        OpInitKey, OpKey: ak = kv;
        OpCol: begin
          ce = 1;
          cs = 2'(ops[0].col);
          me = (ops[0].rnd < Nr);
        end
        default: ov = 1;
      endcase
    end
    return {rdy, ld, bsy, ce, cs, me, ak, ov, rn};
  endfunction

  task automatic model_step(input logic r, input logic iv, input logic kv, input logic orr);
    op_t o;
    if (r) begin
      ops.delete();
      idle_round = 0;
    end else if (ops.size() == 0) begin
      if (iv) begin
        o.kind = OpInitKey; o.rnd = 0; o.col = 0; ops.push_back(o);
        for (int rr = 1; rr <= Nr; rr++) begin
          for (int c = 0; c < 4; c++) begin
            o.kind = OpCol; o.rnd = rr; o.col = c; ops.push_back(o);
          end
          o.kind = OpKey; o.rnd = rr; o.col = 0; ops.push_back(o);
        end
        o.kind = OpDone; o.rnd = Nr; o.col = 0; ops.push_back(o);
      end
    end else begin
      case (ops[0].kind)
        OpInitKey, OpKey: if (kv) void'(ops.pop_front());
        OpCol: void'(ops.pop_front());
        default: if (orr) begin
          void'(ops.pop_front());
          idle_round = Nr;
        end
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic iv, input logic kv, input logic orr,
                      input string tag);
    logic [12:0] got;
    @(negedge clk);
    rst = r; in_valid = iv; key_valid = kv; out_ready = orr;
    #1;
    obs_ov = out_valid;
    if (!r) begin
      got = {in_ready, load_en, busy, col_en, (col_en ? col_sel : 2'b00), mix_en,
             add_key_en, out_valid, round_num};
      check(tag, {3'b000, got}, {3'b000, model_out(iv, kv)});
    end
    @(posedge clk);
    model_step(r, iv, kv, orr);
  endtask

  function automatic logic head_is(input op_kind_e k, input int rnd, input int col);
    if (ops.size() == 0) return 1'b0;
    return (ops[0].kind == k) && (ops[0].rnd == rnd) && (ops[0].col == col);
  endfunction

  // Accept a block and run it to completion; key_valid drops for stall_len cycles
  // while the KEY step of stall_round is pending. Returns -1 if no completion.
  task automatic run_block(input int stall_round, input int stall_len, output int lat);
    int stalled;
    logic kv;
    stalled = 0;
    lat = -1;
    tick(1'b0, 1'b1, 1'b1, 1'b1, "accept");
    for (int k = 1; k < 400; k++) begin
      kv = 1'b1;
      if (head_is(OpKey, stall_round, 0) && stalled < stall_len) begin
        kv = 1'b0;
        stalled++;
      end
      tick(1'b0, 1'b0, kv, 1'b1, "run");
      if (obs_ov) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [7:0] rs;

    tick(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    tick(1'b1, 1'b1, 1'b1, 1'b0, "reset");
    tick(1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
    check("reset_rn_busy", {11'd0, busy, round_num}, 16'd0);

    // Nominal latency with key_valid high throughout.
    run_block(0, 0, lat);
    check("latency_nominal", 16'(lat), 16'(2 + 5 * Nr));
    tick(1'b0, 1'b0, 1'b1, 1'b1, "idle_after");

    // Three-cycle key stall in round 4.
    run_block(4, 3, lat);
    check("latency_stall", 16'(lat), 16'(2 + 5 * Nr + 3));

    // Held output with in_valid asserted throughout DONE.
    tick(1'b0, 1'b1, 1'b1, 1'b0, "accept_hold");
    for (int k = 0; k < 400 && !head_is(OpDone, Nr, 0); k++)
      tick(1'b0, 1'b1, 1'b1, 1'b0, "to_done");
    check("reached_done", {15'd0, head_is(OpDone, Nr, 0)}, 16'd1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1, 1'b0, "done_hold");
    tick(1'b0, 1'b1, 1'b1, 1'b1, "done_release");
    tick(1'b0, 1'b1, 1'b1, 1'b1, "reaccept");
    for (int k = 0; k < 400 && ops.size() != 0; k++)
      tick(1'b0, 1'b0, 1'b1, 1'b1, "drain");

    // Reset during COL of round 6, then a clean block.
    tick(1'b0, 1'b1, 1'b1, 1'b1, "accept_rst");
    for (int k = 0; k < 400 && !head_is(OpCol, 6, 1); k++)
      tick(1'b0, 1'b0, 1'b1, 1'b1, "to_rnd6");
    check("reached_rnd6", {15'd0, head_is(OpCol, 6, 1)}, 16'd1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, "mid_rst");
    tick(1'b0, 1'b0, 1'b1, 1'b1, "post_rst");
    check("post_rst_state", {10'd0, in_ready, busy, round_num}, 16'h0020);
    run_block(0, 0, lat);
    check("latency_after_rst", 16'(lat), 16'(2 + 5 * Nr));

    // Random handshake traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      rs = 8'($urandom_range(0, 255));
      tick(rs == 8'd0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) < 3, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: synchronous active-high reset.
REQ-004 Port in_valid, input, 1: a new 128-bit block is presented to the datapath.
REQ-005 Port in_ready, output, 1: scheduler can accept a block.
REQ-006 Port load_en, output, 1: datapath captures the input block into its state register.
REQ-007 Port key_valid, input, 1: the round key for round_num is available from the key schedule.
REQ-008 Port round_num, output, 4: current round index, also the key-schedule request index.
REQ-009 Port col_en, output, 1: shared column unit processes column col_sel this cycle.
REQ-010 Port col_sel, output, 2: column index 0..3.
REQ-011 Port mix_en, output, 1: MixColumns applied in the current column operation.
REQ-012 Port add_key_en, output, 1: XOR round key into the state this cycle.
REQ-013 Port out_valid, output, 1: state holds the finished ciphertext.
REQ-014 Port out_ready, input, 1: consumer accepts the ciphertext.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have five states: IDLE, INIT_KEY, COL, KEY, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 SHALL pulse load_en for that cycle, set round_num=0 and go to INIT_KEY.
REQ-018 INIT_KEY: hold while key_valid=0; on key_valid=1 pulse add_key_en, set round_num=1, clear col_sel and go to COL.
REQ-019 COL: col_en=1 for exactly 4 consecutive cycles with col_sel 0,1,2,3, then go to KEY.
REQ-020 In COL, mix_en=1 when round_num<NR and mix_en=0 when round_num=NR.
REQ-021 KEY: hold while key_valid=0; on key_valid=1 pulse add_key_en for one cycle.
REQ-022 On that KEY cycle: if round_num=NR go to DONE, else increment round_num and go to COL.
REQ-023 DONE: out_valid=1 and held until out_ready=1; on out_ready=1 go to IDLE.
REQ-024 in_ready SHALL be 0 outside IDLE, so in_valid in DONE is not accepted until the cycle after the IDLE transition.
REQ-025 With key_valid tied high, out_valid SHALL rise 2+5*NR cycles after the accept cycle.
REQ-026 col_en, add_key_en and load_en SHALL never be high in the same cycle.
REQ-027 round_num SHALL never exceed NR.

Reset
REQ-028 When rst=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-029 Reset values: round_num=0, col_sel=0, and all strobes, out_valid and busy 0; in_ready=1 from the first cycle after reset.
REQ-030 Reset mid-operation SHALL discard the in-flight block without asserting out_valid.

Configuration
REQ-031 Macro AES_KEY256_EN SHALL select the round count.
REQ-032 With AES_KEY256_EN defined, NR=14 (AES-256) and the latency is 72 cycles.
REQ-033 Without AES_KEY256_EN, NR=10 (AES-128) and the latency is 52 cycles.
REQ-034 Port widths SHALL be identical in both configurations.

Structure
REQ-035 Package aes_pkg SHALL hold NR_128=10, NR_256=14, the selected NR, and the state enum type.
REQ-036 The block SHALL have no sub-modules; a single FSM, a 4-bit round counter and a 2-bit column counter.
REQ-037 The column datapath and key schedule SHALL be instantiated by the parent, not inside this block.

Verification
REQ-038 Single block, AES-128, key_valid=1, out_ready=1 -> load_en at cycle 0, add_key_en at cycles 1,6,...,51, out_valid at cycle 52.
REQ-039 Final round -> col_en with mix_en=0 for all 4 columns of round 10; mix_en=1 in rounds 1..9.
REQ-040 key_valid low for 3 cycles in KEY of round 4 -> FSM holds, no strobes, completion delayed exactly 3 cycles.
REQ-041 out_ready low 5 cycles in DONE with in_valid=1 -> out_valid held, in_ready=0, no load_en until IDLE.
REQ-042 rst=1 during COL of round 6 -> next cycle IDLE, round_num=0, no out_valid, new block then completes normally.
REQ-043 AES_KEY256_EN defined -> round_num reaches 14, out_valid at cycle 72.
